// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and parameter legality helper for the pipelined
// carry-look-ahead adder.
package pipelined_cla_adder_pkg;

  localparam int GRP_W = 4;

  function automatic bit width_ok(input int w);
    return (w >= GRP_W) && (w <= 64) && ((w % GRP_W) == 0);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-look-ahead group; every carry is a flat
// sum-of-products of generate/propagate terms and the group carry-in.
module cla_group4
  import pipelined_cla_adder_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             c_in,
  output logic [GRP_W-1:0] sum,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [GRP_W-1:0] g;
  logic [GRP_W-1:0] p;
  logic [GRP_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign sum      = p ^ c[GRP_W-1:0];
  assign c_out    = c[GRP_W];
  assign c_msb_in = c[GRP_W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Adder/subtractor pipelined one 4-bit look-ahead group per stage, with
// valid/ready handshaking and collapsing bubbles.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NGRP = WIDTH / GRP_W;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Subtraction is folded in up front so every stage only ever adds.
  assign b_eff   = sub ? ~b : b;
  assign c_first = sub | cin;

  for (genvar k = 0; k < NGRP; k++) begin : g_stg
    localparam int LO = k * GRP_W;

    logic [WIDTH-LO-1:0]    ra;
    logic [WIDTH-LO-1:0]    rb;
    logic                   gci;
    logic                   gco;
    logic                   gcm;
    logic [GRP_W-1:0]       gs;
    logic                   v_in;
    logic                   en;
    logic [LO+GRP_W-1:0]    s_cur;

    if (k == 0) begin : g_in
      assign ra    = a;
      assign rb    = b_eff;
      assign gci   = c_first;
      assign v_in  = in_valid & adv;
      assign s_cur = gs;
    end else begin : g_in
      assign ra    = g_stg[k-1].g_reg.a_q;
      assign rb    = g_stg[k-1].g_reg.b_q;
      assign gci   = g_stg[k-1].g_reg.c_q;
      assign v_in  = g_stg[k-1].g_reg.v_q;
      assign s_cur = {gs, g_stg[k-1].g_reg.s_q};
    end

    cla_group4 u_grp (
      .a        (ra[GRP_W-1:0]),
      .b        (rb[GRP_W-1:0]),
      .c_in     (gci),
      .sum      (gs),
      .c_out    (gco),
      .c_msb_in (gcm)
    );

    if (k < NGRP - 1) begin : g_reg
      logic [WIDTH-LO-GRP_W-1:0] a_q;
      logic [WIDTH-LO-GRP_W-1:0] b_q;
      logic [LO+GRP_W-1:0]       s_q;
      logic                      c_q;
      logic                      v_q;

      // An empty stage may always refill, so bubbles collapse under a stall.
      assign en = g_stg[k+1].en | ~v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
        end else if (en) begin
          v_q <= v_in;
          c_q <= gco;
          a_q <= ra[WIDTH-LO-1:GRP_W];
          b_q <= rb[WIDTH-LO-1:GRP_W];
          s_q <= s_cur;
        end
      end
    end else begin : g_out
      assign en = adv;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (en) begin
          out_valid <= v_in;
          sum       <= s_cur;
          cout      <= gco;
          ovf       <= gcm ^ gco;
          zero      <= (s_cur == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed table at WIDTH=16, stall/reset sequences,
// and randomized runs at WIDTH 16, 4, 8 and 32 against an arithmetic model.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic        ovf;
    logic        zero;
    logic        cout;
    logic [63:0] sum;
  } res_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] cyc;
  } txn_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_n_w;
  logic [31:0] cyc = 32'd0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Reference: plain integer arithmetic and signed-range rules.
  function automatic res_t refModel(input int w, input logic [63:0] a,
                                    input logic [63:0] b, input logic cin,
                                    input logic sub);
    logic [64:0] mask;
    logic [64:0] total;
    logic [63:0] am;
    logic [63:0] bm;
    logic [63:0] s;
    logic        sa, sb, ss;
    res_t        r;
    mask = (65'd1 << w) - 65'd1;
    am   = a & mask[63:0];
    bm   = b & mask[63:0];
    if (sub) begin
      s      = (am - bm) & mask[63:0];
      r.cout = (am >= bm);
    end else begin
      total  = {1'b0, am} + {1'b0, bm} + {64'd0, cin};
      s      = total[63:0] & mask[63:0];
      r.cout = total[w];
    end
    sa     = am[w-1];
    sb     = bm[w-1];
    ss     = s[w-1];
    r.sum  = s;
    r.zero = (s == 64'd0);
    r.ovf  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [71:0] act,
                             input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- WIDTH=16 device ----------------
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic        cout, ovf, zero;
  logic [15:0] a, b, sum;
  logic        mon_en;
  int          n_out16 = 0;
  txn_t        q16[$];

  pipelined_cla_adder #(.WIDTH(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always @(negedge clk) begin
    txn_t t;
    if (mon_en && rst_n) begin
      if (out_valid && out_ready) begin
        if (q16.size() == 0) begin
          checkOutput("w16_stray_result", {71'd0, out_valid}, 72'd0);
        end else begin
          t = q16.pop_front();
          n_out16++;
          checkOutput("w16_result", {5'd0, ovf, zero, cout, 48'd0, sum},
                      {5'd0, refModel(16, t.a, t.b, t.cin, t.sub)});
        end
      end
      if (in_valid && in_ready)
        q16.push_back({48'd0, a, 48'd0, b, cin, sub, cyc});
    end
  end

  task automatic applyStimulus(input vec_t v, output int lat);
    @(posedge clk);
    #1;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic driveRandom16();
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // ---------------- WIDTH 4 / 8 / 32 devices ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int W = (gi == 0) ? 4 : (gi == 1) ? 8 : 32;
    logic         iv, ir, c, s, ov, orr, co, of, z, done;
    logic [W-1:0] wa, wb, ws;
    txn_t         q[$];

    pipelined_cla_adder #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n_w),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (wa),
      .b         (wb),
      .cin       (c),
      .sub       (s),
      .out_valid (ov),
      .out_ready (orr),
      .sum       (ws),
      .cout      (co),
      .ovf       (of),
      .zero      (z)
    );

    always @(negedge clk) begin
      txn_t t;
      if (rst_n_w) begin
        if (ov && orr) begin
          if (q.size() == 0) begin
            checkOutput($sformatf("w%0d_stray_result", W), {71'd0, ov}, 72'd0);
          end else begin
            t = q.pop_front();
            checkOutput($sformatf("w%0d_result", W),
                        {5'd0, of, z, co, 64'(ws)},
                        {5'd0, refModel(W, t.a, t.b, t.cin, t.sub)});
            checkOutput($sformatf("w%0d_latency", W), 72'(cyc - t.cyc), 72'(W / 4));
          end
        end
        if (iv && ir) q.push_back({64'(wa), 64'(wb), c, s, cyc});
      end
    end

    initial begin
      int acc;
      int tries;
      done = 1'b0;
      iv = 1'b0; orr = 1'b1; wa = '0; wb = '0; c = 1'b0; s = 1'b0;
      acc = 0;
      tries = 0;
      wait (rst_n_w);
      while (acc < 500 && tries < 5000) begin
        @(posedge clk);
        #1;
        iv = ($urandom_range(0, 4) != 0);
        wa = W'($urandom);
        wb = W'($urandom);
        c  = 1'($urandom);
        s  = 1'($urandom);
        @(negedge clk);
        if (iv && ir) acc++;
        tries++;
      end
      @(posedge clk);
      #1;
      iv = 1'b0;
      repeat (W / 4 + 3) @(negedge clk);
      #1;
      checkOutput($sformatf("w%0d_accepted", W), 72'(acc), 72'd500);
      checkOutput($sformatf("w%0d_drained", W), 72'(q.size()), 72'd0);
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  vec_t        vecs[10];
  logic [18:0] held;

  initial begin
    int lat;
    int acc;
    int waited;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    mon_en = 1'b0;
    rst_n = 1'b0;
    rst_n_w = 1'b0;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", {71'd0, out_valid}, 72'd0);
    checkOutput("rst_in_ready", {71'd0, in_ready}, 72'd1);
    checkOutput("rst_sum", {56'd0, sum}, 72'd0);
    checkOutput("rst_flags", {69'd0, cout, ovf, zero}, 72'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rst_n_w = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], lat);
      checkOutput($sformatf("vec%0d_latency", i), 72'(lat), 72'd4);
      checkOutput($sformatf("vec%0d_sum", i), {56'd0, sum}, {56'd0, vecs[i].sum});
      checkOutput($sformatf("vec%0d_cout", i), {71'd0, cout}, {71'd0, vecs[i].cout});
      checkOutput($sformatf("vec%0d_ovf", i), {71'd0, ovf}, {71'd0, vecs[i].ovf});
      checkOutput($sformatf("vec%0d_zero", i), {71'd0, zero}, {71'd0, vecs[i].zero});
    end
    @(posedge clk);
    repeat (2) @(negedge clk);

    // Back-to-back stream: 1000 results must all arrive exactly 4 cycles later.
    mon_en = 1'b1;
    acc = 0;
    while (acc < 1000) begin
      driveRandom16();
      @(negedge clk);
      if (in_ready) acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("stream_count", 72'(n_out16), 72'd1000);
    checkOutput("stream_drained", 72'(q16.size()), 72'd0);

    // Stall with a full pipeline.
    repeat (8) driveRandom16();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    held = {sum, cout, ovf, zero};
    for (int i = 0; i < 6; i++) begin
      driveRandom16();
      @(negedge clk);
      checkOutput($sformatf("stall%0d_in_ready", i), {71'd0, in_ready}, 72'd0);
      checkOutput($sformatf("stall%0d_out_valid", i), {71'd0, out_valid}, 72'd1);
      checkOutput($sformatf("stall%0d_held", i), {53'd0, sum, cout, ovf, zero}, {53'd0, held});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) driveRandom16();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checkOutput("stall_drained", 72'(q16.size()), 72'd0);

    // Reset with one result at the output and three in flight.
    out_ready = 1'b0;
    repeat (4) driveRandom16();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    q16.delete();
    checkOutput("midrst_out_valid", {71'd0, out_valid}, 72'd0);
    checkOutput("midrst_in_ready", {71'd0, in_ready}, 72'd1);
    @(posedge clk);
    #1;
    checkOutput("midrst_sum", {56'd0, sum}, 72'd0);
    checkOutput("midrst_flags", {69'd0, cout, ovf, zero}, 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("postrst%0d_out_valid", i), {71'd0, out_valid}, 72'd0);
    end
    repeat (3) driveRandom16();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("postrst_drained", 72'(q16.size()), 72'd0);

    waited = 0;
    while (!(g_w[0].done && g_w[1].done && g_w[2].done) && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("width_runs_done", {69'd0, g_w[0].done, g_w[1].done, g_w[2].done}, 72'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have derived constant NGRP = WIDTH/4, meaning the number of 4-bit look-ahead groups and the pipeline depth.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 SHALL have port cin, input, 1 bit: carry-in, ignored when sub=1.
REQ-009 SHALL have port sub, input, 1 bit: 0 means a+b+cin; 1 means a-b, computed as a+~b+1.
REQ-010 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream consumes the result.
REQ-012 SHALL have port sum, output, WIDTH bits: the result.
REQ-013 SHALL have port cout, output, 1 bit: carry-out of the MSB; for sub, 1 means no borrow.
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-015 SHALL have port zero, output, 1 bit: sum equals 0.

Function
REQ-016 Transfer: an input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-017 Pipeline: the pipeline SHALL have NGRP register stages; stage k (k = 0 .. NGRP-1) computes group k, operand bits 4k+3 down to 4k, using the carry registered by stage k-1 (stage 0 uses cin, or 1 when sub=1).
REQ-018 Group logic: each group SHALL form per-bit generate = a&b and propagate = a^b, and compute its internal carries and carry-out by two-level look-ahead (no ripple inside a group).
REQ-019 Data skew: not-yet-used operand bits SHALL travel forward with each stage, and completed sum bits SHALL travel forward to the output, so that results emerge in order.
REQ-020 Latency: with no stall, a result SHALL appear on out_valid exactly NGRP cycles after its input transfer.
REQ-021 Throughput: with no stall, the block SHALL accept one operand set per cycle.
REQ-022 Stall: the pipeline SHALL advance only when adv = !out_valid | out_ready; when adv is 0, all stages hold.
REQ-023 in_ready SHALL equal adv, combinationally.
REQ-024 Bubbles: each stage SHALL carry a valid bit, and empty stages advance even while the output is held, i.e. bubbles collapse.
REQ-025 Held output: while out_valid=1 and out_ready=0, sum, cout, ovf and zero SHALL remain stable.
REQ-026 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, using the inverted b when sub=1.
REQ-027 zero SHALL be computed from the final sum in the last stage and registered with it.
REQ-028 Simultaneous events: a new input accepted in the same cycle that the output transfers SHALL both succeed, with no bubble inserted.
REQ-029 Sizing: WIDTH=4 SHALL degenerate to a single registered stage with latency 1.

Reset
REQ-030 When rst_n=0, all stage valid bits and out_valid SHALL clear immediately (asynchronously); sum, cout, ovf and zero SHALL reset to 0.
REQ-031 A reset during operation SHALL discard all in-flight operands, and no stale result SHALL ever appear after reset.
REQ-032 in_ready SHALL be 1 during and after reset, since out_valid=0.

Structure
REQ-033 A shared package SHALL hold the group width constant (4) and the WIDTH legality check function.
REQ-034 The block SHALL use one sub-module, cla_group4, a combinational 4-bit look-ahead group:
- inputs: a, b, c_in
- outputs: sum, c_out, c_msb_in (for ovf)
REQ-035 The block SHALL instantiate NGRP copies of cla_group4 through a generate loop.

Verification
REQ-036 Scenario 1 (WIDTH=16): a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles: sum=0x0000, cout=1, ovf=0, zero=1.
REQ-037 Scenario 2 (WIDTH=16): a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1, zero=0; also a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1.
REQ-038 Scenario 3: 1000 random back-to-back operand sets with out_ready=1 -> one result per cycle, in order, each matching the reference model a+b+cin or a-b.
REQ-039 Scenario 4: hold out_ready=0 for 6 cycles while the pipeline is full -> in_ready=0, outputs stable, no input lost or duplicated after release.
REQ-040 Scenario 5: assert rst_n=0 for 1 cycle with 3 results in flight -> out_valid=0 immediately, and none of those 3 results ever appears afterwards.
REQ-041 Scenario 6: run WIDTH in {4, 8, 32} with 500 random vectors each -> latency equals WIDTH/4 and all results match the model.
